alu_pipe: RTL

Parametrised, registered successor to the team's 4-bit combinational ALU.
- Operand width is generalised to WIDTH.
- The opcode set is extended to eight operations.
- Results pass through one pipeline register with valid/ready handshakes on both sides.
- The block also produces carry/zero/overflow flags and counts accepted operations.
- It sits between an operand source (sequencer or register file) and a result consumer that may apply backpressure.

---
 rtl/alu_pipe_pkg.sv | 20 ++
 rtl/alu_pipe_core.sv | 66 ++++++
 rtl/alu_pipe.sv | 77 +++++++
 3 files changed

// File: rtl/alu_pipe_pkg.sv
// Shared opcode encodings and flag bundle for the pipelined ALU.
// The result/flag struct is declared inside each module, where WIDTH is known.
package alu_pipe_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    typedef struct packed {
        logic carry;
        logic zero;
        logic overflow;
    } alu_flags_t;

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational datapath: result and carry/zero/overflow flags from a, b and sel.
// ALU_PIPE_SAT_EN: when defined, ADD/SUB saturate unsigned instead of wrapping.
module alu_pipe_core
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       sel_i,
    output logic [WIDTH-1:0] result_o,
    output alu_flags_t       flags_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] res;
    logic             cy;
    logic             ovf;

    assign sum  = {1'b0, a_i} + {1'b0, b_i};
    assign diff = {1'b0, a_i} - {1'b0, b_i};

    always_comb begin
        res = '0;
        cy  = 1'b0;
        ovf = 1'b0;
        case (sel_i)
            OP_ADD: begin
                res = sum[WIDTH-1:0];
                cy  = sum[WIDTH];
                ovf = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
`ifdef ALU_PIPE_SAT_EN
                if (sum[WIDTH]) res = '1;
`endif
            end
            OP_SUB: begin
                res = diff[WIDTH-1:0];
                cy  = diff[WIDTH];
                ovf = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);
`ifdef ALU_PIPE_SAT_EN
                if (diff[WIDTH]) res = '0;
`endif
            end
            OP_AND: res = a_i & b_i;
            OP_OR:  res = a_i | b_i;
            OP_XOR: res = a_i ^ b_i;
            OP_NOT: res = ~a_i;
            OP_SHL: begin
                res = {a_i[WIDTH-2:0], 1'b0};
                cy  = a_i[WIDTH-1];
            end
            default: begin
                res = {1'b0, a_i[WIDTH-1:1]};
                cy  = a_i[0];
            end
        endcase
    end

    // zero follows the final (possibly saturated) result
    assign result_o         = res;
    assign flags_o.carry    = cy;
    assign flags_o.zero     = (res == '0);
    assign flags_o.overflow = ovf;

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU stage with valid/ready on both sides and an accepted-operation counter.
// ALU_PIPE_SAT_EN selects saturating ADD/SUB inside alu_pipe_core.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             overflow,
    output logic [CNT_W-1:0] op_count
);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        alu_flags_t       flags;
    } alu_res_t;

    alu_res_t         core_res;
    alu_res_t         res_q, res_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;

    alu_pipe_core #(.WIDTH(WIDTH)) u_core (
        .a_i      (a),
        .b_i      (b),
        .sel_i    (sel),
        .result_o (core_res.result),
        .flags_o  (core_res.flags)
    );

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        res_d   = res_q;
        valid_d = valid_q && !out_ready;
        cnt_d   = cnt_q;
        if (accept) begin
            res_d   = core_res;
            valid_d = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            res_q   <= res_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign result    = res_q.result;
    assign carry     = res_q.flags.carry;
    assign zero      = res_q.flags.zero;
    assign overflow  = res_q.flags.overflow;
    assign op_count  = cnt_q;

endmodule
